// File: rtl/uart_tx_mmio_if.sv
// Bus-side port bundle of the memory-mapped UART transmitter.
// Signal names match the synchronous memory slave on the data bus:
//   re_i, we_i   read / write request (chip select already applied)
//   ble_i        byte-lane enables for writes
//   add_i        word address (byte address bits [3:2])
//   d_i          write data
//   d_o          registered read data
//   valid_o      access completion strobe
interface uart_tx_mmio_if;
  logic        re_i;
  logic        we_i;
  logic [3:0]  ble_i;
  logic [1:0]  add_i;
  logic [31:0] d_i;
  logic [31:0] d_o;
  logic        valid_o;

  modport master (output re_i, we_i, ble_i, add_i, d_i, input d_o, valid_o);
  modport slave  (input re_i, we_i, ble_i, add_i, d_i, output d_o, valid_o);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and drain interrupt.
// Ports:
//   clk_i     system clock
//   resetn_i  asynchronous active-low reset
//   bus       data-memory slave port (re/we/ble/add/d_i/d_o/valid_o)
//   tx_o      serial output, idle high
//   irq_o     level interrupt: irq enabled, FIFO empty and transmitter idle
// Register map (word address):
//   0 DATA     write pushes d_i[7:0] (lane 0), reads 0
//   1 STATUS   [0] full [1] empty [2] busy [3] overflow [15:8] count;
//              writing 1 to bit 3 (lane 0) clears overflow
//   2 BAUD_DIV [15:0], lanes 0/1; 0 behaves as 1
//   3 CTRL     [0] tx enable [1] irq enable, lane 0
//
// state | meaning
// IDLE  | line high, waiting for enable and a queued byte
// START | start bit (low) for div cycles
// DATA  | eight data bits, LSB first, div cycles each
// STOP  | stop bit (high) for div cycles
module uart_tx_mmio #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  uart_tx_mmio_if.slave bus,
  output logic         tx_o,
  output logic         irq_o
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   baud_q, eff_div;
  logic [15:0]   div_q, div_d;
  logic [15:0]   timer_q, timer_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    ctrl_q;
  logic          ovf_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, busy, tick, pop, push_req, push_ok;
  logic [31:0]   rd_val;
  logic          unused_bus;

  assign unused_bus = &{1'b0, bus.ble_i[3:2], bus.d_i[31:16]};

  assign full     = count_q == CW'(FIFO_DEPTH);
  assign empty    = count_q == '0;
  assign busy     = state_q != IDLE;
  assign eff_div  = (baud_q == 16'd0) ? 16'd1 : baud_q;
  assign tick     = timer_q == 16'd0;
  assign push_req = bus.we_i && (bus.add_i == 2'd0) && bus.ble_i[0];
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    rd_val = '0;
    unique case (bus.add_i)
      2'd0: rd_val = '0;
      2'd1: rd_val = {16'h0, 8'(count_q), 4'h0, ovf_q, busy, empty, full};
      2'd2: rd_val = {16'h0, baud_q};
      2'd3: rd_val = {30'h0, ctrl_q};
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      bus.d_o     <= '0;
      bus.valid_o <= 1'b0;
      baud_q      <= CLKS_PER_BIT;
      ctrl_q      <= '0;
      ovf_q       <= 1'b0;
      irq_o       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      bus.valid_o <= bus.re_i || bus.we_i;
      if (bus.re_i) bus.d_o <= rd_val;
      if (bus.we_i) begin
        unique case (bus.add_i)
          2'd1: if (bus.ble_i[0] && bus.d_i[3]) ovf_q <= 1'b0;
          2'd2: begin
            if (bus.ble_i[0]) baud_q[7:0]  <= bus.d_i[7:0];
            if (bus.ble_i[1]) baud_q[15:8] <= bus.d_i[15:8];
          end
          2'd3: if (bus.ble_i[0]) ctrl_q <= bus.d_i[1:0];
          default: ;
        endcase
      end
      if (push_req && full && !pop) ovf_q <= 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
      irq_o <= ctrl_q[1] && empty && (state_q == IDLE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= bus.d_i[7:0];
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      div_q   <= 16'd1;
      timer_q <= '0;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      timer_q <= timer_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  // The divisor is captured per frame so BAUD_DIV writes never stretch a frame in flight.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    timer_d = timer_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: if (pop) begin
        shift_d = mem[rd_ptr_q];
        div_d   = eff_div;
        timer_d = eff_div - 16'd1;
        state_d = START;
      end
      START: if (tick) begin
        timer_d = div_q - 16'd1;
        bit_d   = '0;
        state_d = DATA;
      end else timer_d = timer_q - 16'd1;
      DATA: if (tick) begin
        timer_d = div_q - 16'd1;
        shift_d = {1'b0, shift_q[7:1]};
        if (bit_q == 3'd7) state_d = STOP;
        else bit_d = bit_q + 3'd1;
      end else timer_d = timer_q - 16'd1;
      STOP: if (tick) state_d = IDLE;
      else timer_d = timer_q - 16'd1;
    endcase
  end

  // tx_o decodes straight from the state flops so reset drives the line high at once.
  always_comb begin
    tx_o = 1'b1;
    pop  = 1'b0;
    unique case (state_q)
      IDLE:  pop  = ctrl_q[0] && !empty;
      START: tx_o = 1'b0;
      DATA:  tx_o = shift_q[0];
      STOP:  tx_o = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: register vector table, read-data
// scoreboard, and a serial-line monitor that checks every frame cycle by cycle
// against a queue of expected {byte, divisor} pairs.
module tb_uart_tx_mmio;
  logic clk = 1'b0;
  logic resetn;
  logic tx, irq;
  always #5 clk = ~clk;

  uart_tx_mmio_if bus_if ();

  uart_tx_mmio #(.CLKS_PER_BIT(16'd868), .FIFO_DEPTH(8)) dut (
    .clk_i(clk), .resetn_i(resetn), .bus(bus_if), .tx_o(tx), .irq_o(irq)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  typedef struct {
    bit          we;
    bit          re;
    logic [1:0]  add;
    logic [3:0]  ble;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int ncyc = 0;
  int last_wr_cyc = 0;
  int irq_rise_cyc = -1;
  bit mon_active = 1'b0;
  frame_t exp_q[$];
  logic [31:0] rd_q[$];
  int frame_start[$];
  int frame_end[$];
  vec_t tbl[21];

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic int fs(input int i);
    if (i < frame_start.size()) return frame_start[i];
    return -1000;
  endfunction

  function automatic int fe(input int i);
    if (i < frame_end.size()) return frame_end[i];
    return -1000;
  endfunction

  // Caller is at a negedge; consecutive calls make back-to-back bus cycles.
  task automatic bus_access(input bit we, input bit re, input logic [1:0] add,
                            input logic [3:0] ble, input logic [31:0] d,
                            input logic [31:0] exp_rd, input string name);
    logic [31:0] e;
    bus_if.we_i  = we;
    bus_if.re_i  = re;
    bus_if.add_i = add;
    bus_if.ble_i = ble;
    bus_if.d_i   = d;
    last_wr_cyc  = ncyc;
    if (re) rd_q.push_back(exp_rd);
    @(negedge clk);
    bus_if.we_i  = 1'b0;
    bus_if.re_i  = 1'b0;
    bus_if.ble_i = 4'h0;
    check({name, "_valid"}, {31'b0, bus_if.valid_o}, 32'd1);
    if (re) begin
      e = rd_q.pop_front();
      check(name, bus_if.d_o, e);
    end
  endtask

  task automatic wr(input logic [1:0] add, input logic [31:0] d, input logic [3:0] ble);
    bus_access(1'b1, 1'b0, add, ble, d, 32'h0, "wr");
  endtask

  task automatic rd(input logic [1:0] add, input logic [31:0] exp, input string name);
    bus_access(1'b0, 1'b1, add, 4'h0, 32'h0, exp, name);
  endtask

  task automatic push_byte(input logic [7:0] b, input int div);
    frame_t f;
    f.data = b;
    f.div  = div;
    exp_q.push_back(f);
    wr(2'd0, {24'h0, b}, 4'b0001);
  endtask

  task automatic wait_tx_idle(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_active) done = 1'b1;
    end
    check({name, "_done"}, {31'b0, done}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus_if.we_i = 1'b0;
    bus_if.re_i = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic tx_monitor();
    frame_t cur;
    int k = 0;
    int errs = 0;
    int first_bad = 0;
    int idx;
    logic exp_bit;
    logic irq_prev = 1'b0;
    bit skip = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        mon_active = 1'b0;
        irq_prev = 1'b0;
        skip = 1'b0;
      end else begin
        if (irq === 1'b1 && irq_prev !== 1'b1 && irq_rise_cyc < 0) irq_rise_cyc = ncyc;
        irq_prev = irq;
        if (skip && tx === 1'b1) skip = 1'b0;
        if (!mon_active && !skip && tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_frame: tx_o low at cycle %0d, want high (nothing queued)", ncyc);
            skip = 1'b1;
          end else begin
            cur = exp_q.pop_front();
            mon_active = 1'b1;
            k = 0;
            errs = 0;
            frame_start.push_back(ncyc);
          end
        end
        if (mon_active) begin
          idx = k / cur.div;
          exp_bit = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : cur.data[idx-1];
          if (tx !== exp_bit) begin
            if (errs == 0) first_bad = k;
            errs++;
          end
          k++;
          if (k == 10 * cur.div) begin
            mon_active = 1'b0;
            frame_end.push_back(ncyc);
            n_total++;
            if (errs == 0) n_pass++;
            else $display("FAIL tx_frame: byte 0x%02h div %0d got %0d wrong cycles (first at %0d), want 0",
                          cur.data, cur.div, errs, first_bad);
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    //        we    re    add   ble      d              expected read
    tbl[0]  = '{1'b0, 1'b1, 2'd0, 4'h0, 32'h0,         32'h0};
    tbl[1]  = '{1'b0, 1'b1, 2'd1, 4'h0, 32'h0,         32'h2};
    tbl[2]  = '{1'b0, 1'b1, 2'd2, 4'h0, 32'h0,         32'd868};
    tbl[3]  = '{1'b0, 1'b1, 2'd3, 4'h0, 32'h0,         32'h0};
    tbl[4]  = '{1'b1, 1'b0, 2'd2, 4'h1, 32'hFFFF_1234, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 2'd2, 4'h0, 32'h0,         32'h0334};
    tbl[6]  = '{1'b1, 1'b0, 2'd2, 4'h2, 32'h0000_AB00, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 2'd2, 4'h0, 32'h0,         32'hAB34};
    tbl[8]  = '{1'b1, 1'b0, 2'd2, 4'hC, 32'h5555_0000, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 2'd2, 4'h0, 32'h0,         32'hAB34};
    tbl[10] = '{1'b1, 1'b0, 2'd3, 4'h1, 32'hFFFF_FFFE, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 2'd3, 4'h0, 32'h0,         32'h2};
    tbl[12] = '{1'b1, 1'b0, 2'd3, 4'hE, 32'hFFFF_FFFF, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 2'd3, 4'h0, 32'h0,         32'h2};
    tbl[14] = '{1'b1, 1'b1, 2'd3, 4'h1, 32'h1,         32'h2};
    tbl[15] = '{1'b0, 1'b1, 2'd3, 4'h0, 32'h0,         32'h1};
    tbl[16] = '{1'b1, 1'b0, 2'd3, 4'h1, 32'h0,         32'h0};
    tbl[17] = '{1'b1, 1'b0, 2'd1, 4'h1, 32'hFFFF_FFFF, 32'h0};
    tbl[18] = '{1'b0, 1'b1, 2'd1, 4'h0, 32'h0,         32'h2};
    tbl[19] = '{1'b1, 1'b0, 2'd0, 4'h0, 32'h0000_0055, 32'h0};
    tbl[20] = '{1'b0, 1'b1, 2'd1, 4'h0, 32'h0,         32'h2};

    bus_if.we_i = 1'b0;
    bus_if.re_i = 1'b0;
    bus_if.ble_i = 4'h0;
    bus_if.add_i = 2'd0;
    bus_if.d_i = 32'h0;
    resetn = 1'b0;
    fork
      tx_monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_valid", {31'b0, bus_if.valid_o}, 32'd0);
    check("rst_d_o", bus_if.d_o, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 21; i++)
      bus_access(tbl[i].we, tbl[i].re, tbl[i].add, tbl[i].ble, tbl[i].d, tbl[i].exp,
                 $sformatf("reg_vec%0d", i));

    // valid_o is a single-cycle strobe; d_o holds across idle and write cycles
    @(negedge clk);
    check("valid_idle", {31'b0, bus_if.valid_o}, 32'd0);
    wr(2'd3, 32'h0, 4'h1);
    check("d_o_hold", bus_if.d_o, 32'h2);

    // 0xA5 at divisor 4, first low two cycles after the write
    wr(2'd2, 32'd4, 4'h3);
    wr(2'd3, 32'd1, 4'h1);
    frame_start.delete();
    push_byte(8'hA5, 4);
    wait_tx_idle(200, "frame_a5");
    check("start_latency", 32'(fs(0) - last_wr_cyc), 32'd2);

    // divisor 0 behaves as 1
    wr(2'd2, 32'd0, 4'h3);
    push_byte(8'h3A, 1);
    wait_tx_idle(60, "frame_div0");

    // overflow
    wr(2'd3, 32'd0, 4'h1);
    for (int b = 1; b <= 9; b++) wr(2'd0, 32'(b), 4'h1);
    rd(2'd1, 32'h0000_0809, "status_overflow");
    wr(2'd1, 32'h8, 4'h1);
    rd(2'd1, 32'h0000_0801, "status_ovf_clear");
    do_reset();

    // three back-to-back frames at divisor 2, then drain interrupt
    wr(2'd2, 32'd2, 4'h3);
    push_byte(8'h3C, 2);
    push_byte(8'h00, 2);
    push_byte(8'hFF, 2);
    frame_start.delete();
    frame_end.delete();
    irq_rise_cyc = -1;
    wr(2'd3, 32'd3, 4'h1);
    wait_tx_idle(200, "three_frames");
    check("three_frames_count", 32'(frame_start.size()), 32'd3);
    check("gap_1", 32'(fs(1) - fs(0)), 32'd21);
    check("gap_2", 32'(fs(2) - fs(1)), 32'd21);
    check("irq_rise", 32'(irq_rise_cyc - fe(2)), 32'd2);
    check("irq_level", {31'b0, irq}, 32'd1);
    rd(2'd1, 32'h2, "status_drained");
    do_reset();

    // push into a full FIFO in the same cycle as the first pop
    wr(2'd2, 32'd2, 4'h3);
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 2);
    rd(2'd1, 32'h0000_0801, "status_full");
    frame_start.delete();
    wr(2'd3, 32'd1, 4'h1);
    push_byte(8'h18, 2);
    rd(2'd1, 32'h0000_0805, "status_push_pop_full");
    wait_tx_idle(400, "nine_frames");
    check("nine_frames_count", 32'(frame_start.size()), 32'd9);
    rd(2'd1, 32'h2, "status_after_nine");
    do_reset();

    // mid-frame divisor change, then reset during a later frame's data bits
    wr(2'd2, 32'd4, 4'h3);
    push_byte(8'h5A, 4);
    push_byte(8'hC3, 2);
    push_byte(8'h81, 2);
    wr(2'd0, 32'hE7, 4'h1);
    frame_start.delete();
    wr(2'd3, 32'd1, 4'h1);
    repeat (12) @(negedge clk);
    wr(2'd2, 32'd2, 4'h3);
    for (int i = 0; i < 300 && frame_start.size() < 3; i++) @(negedge clk);
    check("third_frame_started", 32'(frame_start.size()), 32'd3);
    s = fs(2);
    for (int i = 0; i < 20 && ncyc < s + 4; i++) @(negedge clk);
    check("tx_low_before_reset", {31'b0, tx}, 32'd0);
    #2 resetn = 1'b0;
    #1 check("tx_async_reset", {31'b0, tx}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rd(2'd1, 32'h2, "status_after_reset");
    rd(2'd2, 32'd868, "baud_after_reset");
    wr(2'd3, 32'd1, 4'h1);
    repeat (60) @(negedge clk);
    check("no_frame_after_reset", 32'(frame_start.size()), 32'd3);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
